// File: rtl/sys_defs.sv
// Shared definitions for the outmap_writer drain path: window/beat sizes,
// the writer state encoding and a strobe helper.
package sys_defs;
   localparam int OUTMAP_BYTES  = 16;
   localparam int WR_BEAT_BYTES = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2,
      DONE    = 2'd3
   } WRITER_STATE;

   // Low n bits set, n in 0..8
   function automatic logic [7:0] strb_mask(input logic [3:0] n);
      logic [8:0] m;
      m = (9'd1 << n) - 9'd1;
      return m[7:0];
   endfunction
endpackage

// File: rtl/outmap_writer_beat_packer.sv
// Combinational merge of the oldest window bytes into the partially filled
// beat; take is bounded by window occupancy, beat space and bytes left.
module beat_packer
   import sys_defs::*;
#(
   parameter int OUT_BYTES = OUTMAP_BYTES,
   parameter int CNT_W     = 20
) (
   input  logic [3:0]                 fill,
   input  logic [CNT_W-1:0]           remaining,
   input  logic [OUT_BYTES-1:0][7:0]  window,
   input  logic [4:0]                 valid_num,
   input  logic [7:0][7:0]            beat_in,
   output logic [4:0]                 take,
   output logic [3:0]                 fill_next,
   output logic [7:0][7:0]            beat_out,
   output logic [7:0]                 strb_out
);
   logic [4:0] vn_c;
   logic [4:0] space;
   logic [4:0] take_lim;

   always_comb begin
      vn_c     = (valid_num > 5'd16) ? 5'd16 : valid_num;
      space    = 5'd8 - {1'b0, fill};
      take_lim = (vn_c < space) ? vn_c : space;
      take     = take_lim;
      if (remaining < {{(CNT_W-5){1'b0}}, take_lim})
         take = remaining[4:0];
      fill_next = fill + take[3:0];
      strb_out  = strb_mask(fill_next);
   end

   // Beat byte k receives window byte k-fill when it lies in the new span
   for (genvar k = 0; k < WR_BEAT_BYTES; k++) begin : g_byte
      localparam logic [4:0] K = 5'(k);
      logic [4:0] idx;
      always_comb begin
         idx         = K - {1'b0, fill};
         beat_out[k] = beat_in[k];
         if (K >= {1'b0, fill} && K < ({1'b0, fill} + take))
            beat_out[k] = window[idx[3:0]];
      end
   end
endmodule

// File: rtl/outmap_writer.sv
// Drains the output_buffer window into 64-bit memory write beats; holds the
// control FSM, byte counters, address and the beat being assembled.
module outmap_writer
   import sys_defs::*;
#(
   parameter int OUT_BYTES  = OUTMAP_BYTES,
   parameter int BEAT_BYTES = WR_BEAT_BYTES,
   parameter int ADDR_W     = 32,
   parameter int CNT_W      = 20
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [ADDR_W-1:0]         base_addr,
   input  logic [CNT_W-1:0]          total_bytes,
   input  logic [OUT_BYTES-1:0][7:0] outmap_data,
   input  logic [4:0]                outmap_data_valid_num,
   output logic [4:0]                valid_taken_num,
   output logic                      mem_wr_valid,
   output logic [ADDR_W-1:0]         mem_wr_addr,
   output logic [63:0]               mem_wr_data,
   output logic [7:0]                mem_wr_strb,
   input  logic                      mem_wr_ready,
   output logic                      busy,
   output logic                      done
);
   WRITER_STATE           state;
   logic [3:0]            fill;
   logic [CNT_W-1:0]      remaining;
   logic [ADDR_W-1:0]     addr;
   logic [7:0][7:0]       beat_q;
   logic [7:0]            strb_q;

   logic [4:0]            take;
   logic [3:0]            fill_next;
   logic [7:0][7:0]       beat_next;
   logic [7:0]            strb_next;
   logic [CNT_W-1:0]      rem_next;

   beat_packer #(.OUT_BYTES(OUT_BYTES), .CNT_W(CNT_W)) u_packer (
      .fill      (fill),
      .remaining (remaining),
      .window    (outmap_data),
      .valid_num (outmap_data_valid_num),
      .beat_in   (beat_q),
      .take      (take),
      .fill_next (fill_next),
      .beat_out  (beat_next),
      .strb_out  (strb_next)
   );

   assign rem_next = remaining - {{(CNT_W-5){1'b0}}, take};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         fill      <= '0;
         remaining <= '0;
         addr      <= '0;
         beat_q    <= '0;
         strb_q    <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               addr      <= base_addr & ~ADDR_W'(7);
               remaining <= total_bytes;
               fill      <= '0;
               beat_q    <= '0;
               strb_q    <= '0;
               state     <= (total_bytes == '0) ? DONE : COLLECT;
            end
            COLLECT: begin
               beat_q    <= beat_next;
               strb_q    <= strb_next;
               fill      <= fill_next;
               remaining <= rem_next;
               if (fill_next == 4'(BEAT_BYTES) || rem_next == '0)
                  state <= WRITE;
            end
            WRITE: if (mem_wr_ready) begin
               addr   <= addr + ADDR_W'(BEAT_BYTES);
               fill   <= '0;
               beat_q <= '0;
               strb_q <= '0;
               state  <= (remaining == '0) ? DONE : COLLECT;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Beat fields are only exposed while offered; otherwise held at zero
   always_comb begin
      valid_taken_num = (state == COLLECT) ? take : 5'd0;
      mem_wr_valid    = (state == WRITE);
      mem_wr_addr     = addr;
      mem_wr_data     = (state == WRITE) ? beat_q : 64'd0;
      mem_wr_strb     = (state == WRITE) ? strb_q : 8'd0;
      busy            = (state != IDLE);
      done            = (state == DONE);
   end
endmodule
